// File: rtl/dcache_controller_if.sv
// CPU request/response and data_memory block-port bundle for the data cache.
// master = CPU plus memory side, slave = the cache controller.
interface dcache_controller_if;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         cpu_busy;
    logic [31:0]  read_address;
    logic [127:0] read_data;
    logic [31:0]  write_address;
    logic [127:0] write_data;
    logic         mem_write;
    logic [4:0]   count;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, read_data,
        input  cpu_rdata, cpu_ready, cpu_busy, read_address,
               write_address, write_data, mem_write, count
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, read_data,
        output cpu_rdata, cpu_ready, cpu_busy, read_address,
               write_address, write_data, mem_write, count
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache; hit in 1 cycle, misses L+2 or 2L+3.
// The CPU stalls on cpu_busy; requests are only sampled in IDLE.
module dcache_controller #(
    parameter int LINES       = 16,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    dcache_controller_if.slave bus
);
    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 30 - IDX;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_COMPARE   = 2'd1;
    localparam logic [1:0] S_WRITEBACK = 2'd2;
    localparam logic [1:0] S_ALLOCATE  = 2'd3;

    localparam logic [4:0] CNT_IDLE = 5'd31;
    localparam logic [4:0] CNT_LOAD = 5'(MEM_LATENCY);

    logic [1:0]       state_q, state_d;
    logic [4:0]       count_q, count_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic             req_we_q, req_we_d;
    logic [31:0]      req_wdata_q, req_wdata_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic [TAGW-1:0]  tag_q [LINES];
    logic [127:0]     data_q [LINES];
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      rd_addr_q, rd_addr_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [127:0]     wr_data_q, wr_data_d;

    logic [IDX-1:0]   req_idx;
    logic [TAGW-1:0]  req_tag;
    logic [1:0]       req_off;
    logic [TAGW-1:0]  line_tag;
    logic [127:0]     line_data;
    logic             hit;
    logic             line_we;
    logic [127:0]     line_d;
    logic             in_wb, in_alloc, in_cmp;

    assign req_idx   = req_addr_q[1+IDX:2];
    assign req_tag   = req_addr_q[31:2+IDX];
    assign req_off   = req_addr_q[1:0];
    assign line_tag  = tag_q[req_idx];
    assign line_data = data_q[req_idx];
    assign hit       = valid_q[req_idx] && (line_tag == req_tag);

    // Memory-facing outputs are suppressed in a reset cycle so nothing half-done is committed.
    assign in_wb    = (state_q == S_WRITEBACK) && !reset;
    assign in_alloc = (state_q == S_ALLOCATE) && !reset;
    assign in_cmp   = (state_q == S_COMPARE) && !reset;

    always_comb begin
        state_d     = state_q;
        count_d     = CNT_IDLE;
        req_addr_d  = req_addr_q;
        req_we_d    = req_we_q;
        req_wdata_d = req_wdata_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        line_we     = 1'b0;
        line_d      = line_data;
        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    req_addr_d  = bus.cpu_addr;
                    req_we_d    = bus.cpu_we;
                    req_wdata_d = bus.cpu_wdata;
                    state_d     = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    state_d = S_IDLE;
                    if (req_we_q) begin
                        line_we = 1'b1;
                        line_d[{req_off, 5'd0} +: 32] = req_wdata_q;
                        dirty_d[req_idx] = 1'b1;
                    end
                end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                    state_d = S_WRITEBACK;
                    count_d = CNT_LOAD;
                end else begin
                    state_d = S_ALLOCATE;
                    count_d = CNT_LOAD;
                end
            end
            S_WRITEBACK: begin
                if (count_q == 5'd0) begin
                    state_d = S_ALLOCATE;
                    count_d = CNT_LOAD;
                end else begin
                    count_d = count_q - 5'd1;
                end
            end
            default: begin
                // The block is captured at count 1 so count never hits the commit value here.
                if (count_q == 5'd1) begin
                    line_we          = 1'b1;
                    line_d           = bus.read_data;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    state_d          = S_COMPARE;
                end else begin
                    count_d = count_q - 5'd1;
                end
            end
        endcase
    end

    always_comb begin
        rdata_d   = rdata_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (in_cmp && hit && !req_we_q)
            rdata_d = line_data[{req_off, 5'd0} +: 32];
        if (in_alloc)
            rd_addr_d = {req_addr_q[31:2], 2'b00};
        if (in_wb) begin
            wr_addr_d = {line_tag, req_idx, 2'b00};
            wr_data_d = line_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= CNT_IDLE;
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            rdata_q     <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            req_addr_q  <= req_addr_d;
            req_we_q    <= req_we_d;
            req_wdata_q <= req_wdata_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            rdata_q     <= rdata_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Tag/data storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (line_we && !reset) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= line_d;
        end
    end

    assign bus.cpu_busy      = (state_q != S_IDLE);
    assign bus.cpu_ready     = in_cmp && hit;
    assign bus.cpu_rdata     = rdata_d;
    assign bus.count         = reset ? CNT_IDLE : count_q;
    assign bus.mem_write     = in_wb && (count_q == 5'd0);
    assign bus.read_address  = rd_addr_d;
    assign bus.write_address = wr_addr_d;
    assign bus.write_data    = wr_data_d;
endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache sitting between the MEM pipeline stage and `data_memory`. It services 32-bit word loads and stores from the CPU. It moves whole 128-bit blocks (4 words) to and from `data_memory` through that module's block read and write ports. It also generates the `count` latency signal that `data_memory` uses to select between committing a write and performing a read.

## Interface
- `LINES`, 16: number of cache lines; power of two; index width = log2(LINES).
- `MEM_LATENCY`, 4: memory access latency in cycles; legal range 2..30.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  access request; sampled only when `cpu_busy`=0.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  32  word address; [1:0] = word-in-block, [1+IDX:2] = index, [31:2+IDX] = tag.
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data; valid when `cpu_ready`=1.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_busy`  out  1  1 in every state except IDLE.
- `read_address`  out  32  block address to `data_memory`, {tag, index, 2'b00}.
- `read_data`  in  128  block from `data_memory`; word n is at [32n+31:32n].
- `write_address`  out  32  victim block address, {old tag, index, 2'b00}.
- `write_data`  out  128  victim block, same word packing as `read_data`.
- `mem_write`  out  1  high in the cycle the write is committed.
- `count`  out  5  latency counter to `data_memory`; 0 means "commit write now".

## Operation
- Per-line storage: valid bit, dirty bit, tag, and 128-bit data block.
- The request is latched at acceptance: address, write enable and write data.
- **IDLE**
  - `cpu_busy`=0 and `count`=31.
  - If `cpu_req`=1, latch the request and go to COMPARE.
- **COMPARE**
  - Hit means valid && tag match.
  - Hit, load: `cpu_rdata` = selected word, `cpu_ready`=1, go to IDLE.
  - Hit, store: write the word, set dirty, `cpu_ready`=1, go to IDLE. `cpu_rdata` holds its previous value.
  - Miss on an invalid line, or a valid clean line: go to ALLOCATE.
  - Miss on a valid dirty line: go to WRITEBACK.
- **WRITEBACK**
  - Drive `write_address` and `write_data` from the victim line, stable for the whole state.
  - `count` loads MEM_LATENCY on entry and decrements by 1 per cycle down to 0.
  - In the cycle `count`=0, `mem_write`=1; the next state is ALLOCATE.
- **ALLOCATE**
  - Drive `read_address` = {req tag, index, 2'b00}.
  - `count` loads MEM_LATENCY on entry and decrements per cycle.
  - In the cycle `count`=1, capture `read_data` into the line. Set valid=1, tag=req tag, dirty=0, then return to COMPARE, which now hits.
  - `count` never reaches 0 in ALLOCATE.
- `count` is 0 only in the WRITEBACK commit cycle, because `data_memory` writes whenever `count`=0. In all other cycles it is nonzero; outside WRITEBACK and ALLOCATE it is 31.
- `cpu_req` asserted while `cpu_busy`=1 is ignored; the CPU stalls on `cpu_busy`.
- Address fields outside WRITEBACK and ALLOCATE hold their last value.

## Timing
- Request accepted at cycle T (IDLE, `cpu_req`=1).
- Latency to `cpu_ready` for each outcome, with L = MEM_LATENCY:

  | Outcome | Path | `cpu_ready` at |
  |---|---|---|
  | Hit | COMPARE | T+1 |
  | Clean miss | ALLOCATE T+2..T+1+L, COMPARE | T+L+2 |
  | Dirty miss | WRITEBACK T+2..T+2+L (`mem_write` at T+2+L), ALLOCATE T+3+L..T+2+2L, COMPARE | T+2L+3 |

- Maximum accepted rate is one request every 2 cycles, since `cpu_busy` is high during COMPARE.
- Reset values: state IDLE; all valid and dirty bits 0; `count`=31; `mem_write`=0, `cpu_ready`=0, `cpu_busy`=0; `cpu_rdata`=0; all address and data outputs 0.
- Reset mid-operation:
  - Any miss sequence is abandoned immediately.
  - `mem_write` is 0 in the reset cycle and `count` is forced to 31, so no partial block is committed.
  - The line being filled stays invalid.

## Test plan
- **Cold load:** reset; load addr 0x5 with `data_memory` preloaded (words 4,5,6,7 = 8,5,0,0) → `cpu_ready` at T+6 (L=4), `cpu_rdata`=5; `count` sequence 4,3,2,1 then 31; `mem_write` never high.
- **Hit after fill:** load 0x4 immediately after the cold load → `cpu_ready` at T+1 with `cpu_rdata`=8; no memory activity.
- **Store then evict:**
  - Store 0xDEAD to 0x1 → clean miss fill, dirty set.
  - Then load 0x41 (same index, different tag) → WRITEBACK with `write_address`=0x0, `write_data`[63:32]=0xDEAD, `mem_write` pulse at `count`=0.
  - Then fill → `cpu_ready` at T+11.
- **Busy ignore:** pulse `cpu_req` for a different address during an ALLOCATE → no second access occurs; original request completes unchanged.
- **Reset mid-WRITEBACK:** assert `reset` at `count`=2 → `mem_write` stays 0, `count`=31, memory unchanged; a subsequent load of the victim address misses (valid=0).
- **Clean conflict miss:** fill 0x0 with loads only, then load 0x40 → no WRITEBACK; ALLOCATE only; `cpu_ready` at T+6.
